// File: rtl/pc_fetch_sequencer.sv
// Program-counter stage feeding the program ROM: next-PC selection, target
// checking, RUN/STALL/HALT/FAULT control and a saturating retired-instruction count.
module pc_fetch_sequencer #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter int unsigned           COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   halt_i,
  input  logic                   branch_eq_i,
  input  logic                   branch_ne_i,
  input  logic                   zero_i,
  input  logic                   jump_i,
  input  logic                   jump_reg_i,
  input  logic [DATA_WIDTH-1:0]  rs_data_i,
  input  logic [DATA_WIDTH-1:0]  instruction_i,
  output logic [DATA_WIDTH-1:0]  pc_o,
  output logic [DATA_WIDTH-1:0]  pc_plus4_o,
  output logic [1:0]             state_o,
  output logic                   fault_o,
  output logic [1:0]             fault_cause_o,
  output logic [COUNT_WIDTH-1:0] instr_count_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_WINDOW   = 2'b10;

  // One extra bit so the window end cannot wrap when RESET_PC sits near the top.
  localparam logic [DATA_WIDTH:0] WINDOW_END =
    {1'b0, RESET_PC} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q;
  logic [1:0]              cause_q, target_cause;
  logic [COUNT_WIDTH-1:0]  count_q;
  logic [DATA_WIDTH-1:0]   seq_pc, br_offset, br_pc, jt_pc, next_pc;
  logic                    branch_taken, advance, enter_fault;
  logic                    unused_opcode;

  assign seq_pc       = pc_q + DATA_WIDTH'(4);
  assign br_offset    = {{(DATA_WIDTH-18){instruction_i[15]}}, instruction_i[15:0], 2'b00};
  assign br_pc        = seq_pc + br_offset;
  assign jt_pc        = {seq_pc[DATA_WIDTH-1:28], instruction_i[25:0], 2'b00};
  assign branch_taken = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);
  assign unused_opcode = ^instruction_i[DATA_WIDTH-1:26];

  always_comb begin
    next_pc = seq_pc;
    if (jump_reg_i)        next_pc = rs_data_i;
    else if (jump_i)       next_pc = jt_pc;
    else if (branch_taken) next_pc = br_pc;
  end

  // Misalignment is reported ahead of the window check.
  always_comb begin
    target_cause = CAUSE_NONE;
    if (next_pc[1:0] != 2'b00)
      target_cause = CAUSE_MISALIGN;
    else if ((next_pc < RESET_PC) || ({1'b0, next_pc} >= WINDOW_END))
      target_cause = CAUSE_WINDOW;
  end

  // STALL re-evaluates exactly like RUN, so release costs no bubble cycle.
  always_comb begin
    state_d     = state_q;
    advance     = 1'b0;
    enter_fault = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (halt_i)                          state_d = ST_HALT;
        else if (stall_i)                    state_d = ST_STALL;
        else if (target_cause != CAUSE_NONE) begin
          state_d     = ST_FAULT;
          enter_fault = 1'b1;
        end else begin
          state_d = ST_RUN;
          advance = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cause_q <= CAUSE_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (advance) pc_q <= next_pc;
      if (enter_fault) cause_q <= target_cause;
      if (advance && (count_q != {COUNT_WIDTH{1'b1}}))
        count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus4_o    = seq_pc;
  assign state_o       = state_q;
  assign fault_o       = (state_q == ST_FAULT);
  assign fault_cause_o = cause_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus randomized episodes
// compared against an arithmetic model of the next-PC and control rules.
module tb_pc_fetch_sequencer;

  localparam int          DW    = 32;
  localparam int          CW    = 5;
  localparam int          DEPTH = 32;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic          clk, reset;
  logic          stall, halt, beq, bne, zero, jump, jr;
  logic [DW-1:0] rs_data, instr;
  logic [DW-1:0] pc, pc_plus4;
  logic [1:0]    state, cause;
  logic          fault;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: state uses the output encoding 0 run,1 stall,2 halt,3 fault.
  logic [31:0]   m_pc;
  logic [1:0]    m_state, m_cause;
  logic [CW-1:0] m_count;

  pc_fetch_sequencer #(
    .DATA_WIDTH(DW), .RESET_PC(RPC), .MEMORY_DEPTH(DEPTH), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall), .halt_i(halt),
    .branch_eq_i(beq), .branch_ne_i(bne), .zero_i(zero), .jump_i(jump),
    .jump_reg_i(jr), .rs_data_i(rs_data), .instruction_i(instr),
    .pc_o(pc), .pc_plus4_o(pc_plus4), .state_o(state), .fault_o(fault),
    .fault_cause_o(cause), .instr_count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs;
    stall = 0; halt = 0; beq = 0; bne = 0; zero = 0; jump = 0; jr = 0;
    rs_data = '0; instr = '0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    reset = 1'b1;
    m_pc = RPC; m_state = 2'd0; m_cause = 2'd0; m_count = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] model_target();
    logic [31:0] seq;
    int off;
    seq = m_pc + 32'd4;
    off = $signed(instr[15:0]);
    if (jr)   return rs_data;
    if (jump) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    if ((beq && zero) || (bne && !zero)) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic model_step;
    logic [31:0] t;
    longint lim;
    if (m_state == 2'd2 || m_state == 2'd3) return;
    if (halt) begin m_state = 2'd2; return; end
    if (stall) begin m_state = 2'd1; return; end
    t = model_target();
    lim = longint'(RPC) + 4 * DEPTH;
    if (t % 4 != 0) begin
      m_state = 2'd3; m_cause = 2'd1;
    end else if (t < RPC || longint'(t) >= lim) begin
      m_state = 2'd3; m_cause = 2'd2;
    end else begin
      m_pc = t; m_state = 2'd0;
      if (int'(m_count) < (1 << CW) - 1) m_count = m_count + 1'b1;
    end
  endtask

  task automatic tick;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    apply_reset();
    n_checks++; if (pc !== RPC) $display("FAIL reset_pc: got %h want %h", pc, RPC); else n_pass++;
    n_checks++; if (pc_plus4 !== RPC + 32'd4) $display("FAIL reset_pc4: got %h want %h", pc_plus4, RPC + 32'd4); else n_pass++;
    n_checks++; if (state !== 2'b00) $display("FAIL reset_state: got %b want 00", state); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else n_pass++;
    n_checks++; if (cause !== 2'b00) $display("FAIL reset_cause: got %b want 00", cause); else n_pass++;
    n_checks++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_sequential;
    logic [31:0] exp_pc [3] = '{32'h0040_0004, 32'h0040_0008, 32'h0040_000C};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc !== exp_pc[i]) $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp_pc[i]); else n_pass++;
    end
    n_checks++; if (count !== 5'd3) $display("FAIL seq_count: got %0d want 3", count); else n_pass++;
  endtask

  task automatic test_branch;
    logic [2:0]  cfg [3] = '{3'b101, 3'b100, 3'b110};  // {beq, bne, zero}
    logic [31:0] exp [3] = '{32'h0040_0004, 32'h0040_000C, 32'h0040_0004};
    for (int i = 0; i < 3; i++) begin
      apply_reset();
      tick(); tick();
      instr = 32'h1000_FFFE;
      {beq, bne, zero} = cfg[i];
      tick();
      n_checks++; if (pc !== exp[i]) $display("FAIL branch%0d_pc: got %h want %h", i, pc, exp[i]); else n_pass++;
    end
  endtask

  task automatic test_jump;
    apply_reset();
    instr = 32'h0810_0005; jump = 1;
    tick();
    n_checks++; if (pc !== 32'h0040_0014) $display("FAIL jump_pc: got %h want 00400014", pc); else n_pass++;
    apply_reset();
    instr = 32'h0810_0005; jump = 1; jr = 1; rs_data = 32'h0040_0020;
    tick();
    n_checks++; if (pc !== 32'h0040_0020) $display("FAIL jr_wins_pc: got %h want 00400020", pc); else n_pass++;
  endtask

  task automatic test_stall;
    apply_reset();
    tick();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (pc !== 32'h0040_0004) $display("FAIL stall_pc%0d: got %h want 00400004", i, pc); else n_pass++;
      n_checks++; if (count !== 5'd1) $display("FAIL stall_count%0d: got %0d want 1", i, count); else n_pass++;
      n_checks++; if (state !== 2'b01) $display("FAIL stall_state%0d: got %b want 01", i, state); else n_pass++;
    end
    stall = 0;
    tick();
    n_checks++; if (pc !== 32'h0040_0008) $display("FAIL stall_release_pc: got %h want 00400008", pc); else n_pass++;
    n_checks++; if (state !== 2'b00) $display("FAIL stall_release_state: got %b want 00", state); else n_pass++;
  endtask

  task automatic test_fault;
    apply_reset();
    jr = 1; rs_data = 32'h0040_0006;
    tick();
    n_checks++; if (state !== 2'b11) $display("FAIL mis_state: got %b want 11", state); else n_pass++;
    n_checks++; if (cause !== 2'b01) $display("FAIL mis_cause: got %b want 01", cause); else n_pass++;
    n_checks++; if (fault !== 1'b1) $display("FAIL mis_fault: got %b want 1", fault); else n_pass++;
    n_checks++; if (pc !== RPC) $display("FAIL mis_pc: got %h want %h", pc, RPC); else n_pass++;
    jr = 0;
    tick(); tick();
    n_checks++; if (pc_plus4 !== RPC + 32'd4) $display("FAIL mis_hold_pc4: got %h want %h", pc_plus4, RPC + 32'd4); else n_pass++;
    n_checks++; if (cause !== 2'b01) $display("FAIL mis_hold_cause: got %b want 01", cause); else n_pass++;
    apply_reset();
    jr = 1; rs_data = 32'h0040_0080;
    tick();
    n_checks++; if (cause !== 2'b10) $display("FAIL win_cause: got %b want 10", cause); else n_pass++;
    n_checks++; if (state !== 2'b11) $display("FAIL win_state: got %b want 11", state); else n_pass++;
    // Reset lands between clock edges and must act without waiting for one.
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    n_checks++; if (pc !== RPC) $display("FAIL async_rst_pc: got %h want %h", pc, RPC); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL async_rst_fault: got %b want 0", fault); else n_pass++;
    apply_reset();
  endtask

  task automatic test_halt;
    apply_reset();
    tick(); tick(); tick();
    halt = 1; stall = 1;
    tick();
    n_checks++; if (state !== 2'b10) $display("FAIL halt_state: got %b want 10", state); else n_pass++;
    halt = 0; stall = 0;
    instr = 32'h0810_0005;
    for (int i = 0; i < 10; i++) begin
      jump = i[0];
      tick();
      n_checks++; if (pc !== 32'h0040_000C) $display("FAIL halt_pc%0d: got %h want 0040000c", i, pc); else n_pass++;
    end
    n_checks++; if (count !== 5'd3) $display("FAIL halt_count: got %0d want 3", count); else n_pass++;
    n_checks++; if (state !== 2'b10) $display("FAIL halt_final_state: got %b want 10", state); else n_pass++;
  endtask

  task automatic test_saturate;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      jr = 1; rs_data = RPC + 32'(4 * (i % 8));
      tick();
    end
    n_checks++; if (count !== 5'd31) $display("FAIL sat_count: got %0d want 31", count); else n_pass++;
    n_checks++; if (pc !== RPC + 32'd28) $display("FAIL sat_pc: got %h want %h", pc, RPC + 32'd28); else n_pass++;
  endtask

  task automatic test_random;
    logic [15:0] off;
    int r;
    for (int ep = 0; ep < 8; ep++) begin
      apply_reset();
      for (int c = 0; c < 40; c++) begin
        if (m_state >= 2'd2 && $urandom_range(0, 4) == 0) apply_reset();
        halt  = ($urandom_range(0, 49) == 0);
        stall = ($urandom_range(0, 7) == 0);
        beq   = ($urandom_range(0, 3) == 0);
        bne   = ($urandom_range(0, 3) == 0);
        zero  = 1'($urandom_range(0, 1));
        jump  = ($urandom_range(0, 7) == 0);
        jr    = ($urandom_range(0, 9) == 0);
        off   = 16'($urandom_range(0, 40)) - 16'd8;
        instr = {6'($urandom_range(0, 63)), 10'h010, off};
        r = $urandom_range(0, 9);
        if (r == 0)      rs_data = RPC + 32'($urandom_range(0, 127)) | 32'd1;
        else if (r == 1) rs_data = RPC + 32'd128 + 32'(4 * $urandom_range(0, 8));
        else             rs_data = RPC + 32'(4 * $urandom_range(0, 31));
        tick();
        n_checks++; if (pc !== m_pc) $display("FAIL rnd_pc e%0d c%0d: got %h want %h", ep, c, pc, m_pc); else n_pass++;
        n_checks++; if (pc_plus4 !== m_pc + 32'd4) $display("FAIL rnd_pc4 e%0d c%0d: got %h want %h", ep, c, pc_plus4, m_pc + 32'd4); else n_pass++;
        n_checks++; if (state !== m_state) $display("FAIL rnd_state e%0d c%0d: got %b want %b", ep, c, state, m_state); else n_pass++;
        n_checks++; if (fault !== (m_state == 2'd3)) $display("FAIL rnd_fault e%0d c%0d: got %b want %b", ep, c, fault, m_state == 2'd3); else n_pass++;
        n_checks++; if (cause !== m_cause) $display("FAIL rnd_cause e%0d c%0d: got %b want %b", ep, c, cause, m_cause); else n_pass++;
        n_checks++; if (count !== m_count) $display("FAIL rnd_count e%0d c%0d: got %0d want %0d", ep, c, count, m_count); else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_fault();
    test_halt();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
